// File: rtl/conv_pkg.sv
// Shared definitions for the 2x2-output convolution sequencer.
// Holds the sequencer state encoding and the geometry/data-width constants
// used by pe_conv_sequencer and conv_tap_index.
package conv_pkg;

    localparam int IMG_N  = 4;   // input image is IMG_N x IMG_N
    localparam int KER_N  = 3;   // kernel is KER_N x KER_N
    localparam int OUT_N  = 2;   // output is OUT_N x OUT_N
    localparam int TAPS   = 9;   // KER_N * KER_N multiply-accumulates per output
    localparam int DATA_W = 8;   // operand width

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_tap_index.sv
// Maps (output window, tap number) to the image and kernel byte indices.
// Ports: i_window (0=C11,1=C12,2=C21,3=C22), i_tap (0..8),
//        o_img_idx / o_ker_idx byte indices into the row-major img / ker buses.
module conv_tap_index
    import conv_pkg::*;
(
    input  logic [1:0] i_window,
    input  logic [3:0] i_tap,
    output logic [3:0] o_img_idx,
    output logic [3:0] o_ker_idx
);

    logic [1:0] w_row;
    logic [1:0] w_col;
    logic [1:0] w_r;
    logic [1:0] w_c;

    always_comb begin
        w_row = 2'(i_tap / 4'(KER_N));
        w_col = 2'(i_tap % 4'(KER_N));
        // Window bit 1 selects the row offset, bit 0 the column offset.
        w_r   = {1'b0, i_window[1]} + w_row;
        w_c   = {1'b0, i_window[0]} + w_col;
        // Row stride of the image is 4 bytes, so {row, col} is the byte index.
        o_img_idx = {w_r, w_c};
        // Flipped kernel: tap t pairs with b[3-t/3][3-t%3], i.e. byte 8-t.
        o_ker_idx = 4'(TAPS - 1) - i_tap;
    end

endmodule

// File: rtl/pe_conv_sequencer.sv
// Sequences one 2x2 "valid" convolution (4x4 image, 3x3 kernel) through a single
// MAC processing element: per output window CLR, 9 FEED taps, DRAIN, STORE.
// Ports: i_start/i_abort job control, i_img/i_ker operands (snapshotted at start),
//        o_pe_rst/o_pe_on/o_pe_a/o_pe_w PE drive, o_c_we result strobes, o_busy, o_done.
module pe_conv_sequencer
    import conv_pkg::*;
#(
    parameter int DRAIN_CYC = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic [IMG_N*IMG_N*DATA_W-1:0]   i_img,
    input  logic [KER_N*KER_N*DATA_W-1:0]   i_ker,
    output logic                            o_pe_rst,
    output logic                            o_pe_on,
    output logic [DATA_W-1:0]               o_pe_a,
    output logic [DATA_W-1:0]               o_pe_w,
    output logic [OUT_N*OUT_N-1:0]          o_c_we,
    output logic                            o_busy,
    output logic                            o_done
);

    state_t                          r_state, w_state;
    logic [1:0]                      r_window, w_window;
    logic [3:0]                      r_tap, w_tap;
    logic [1:0]                      r_drain, w_drain;
    logic [IMG_N*IMG_N*DATA_W-1:0]   r_img;
    logic [KER_N*KER_N*DATA_W-1:0]   r_ker;
    logic                            w_load;
    logic                            w_aborted;

    logic                            w_pe_rst, w_pe_on, w_busy, w_done;
    logic [DATA_W-1:0]               w_pe_a, w_pe_w;
    logic [OUT_N*OUT_N-1:0]          w_c_we;
    logic [3:0]                      w_img_idx, w_ker_idx;

    // Indices are computed from the next-state counters so that the operands
    // registered at this edge belong to the tap the state register will hold.
    conv_tap_index u_tap_index (
        .i_window  (w_window),
        .i_tap     (w_tap),
        .o_img_idx (w_img_idx),
        .o_ker_idx (w_ker_idx)
    );

    // Next-state and counter logic.
    always_comb begin
        w_state   = r_state;
        w_window  = r_window;
        w_tap     = r_tap;
        w_drain   = r_drain;
        w_load    = 1'b0;
        w_aborted = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state  = S_CLR;
                    w_window = 2'd0;
                    w_load   = 1'b1;
                end
            end
            S_CLR: begin
                w_state = S_FEED;
                w_tap   = 4'd0;
            end
            S_FEED: begin
                if (r_tap == 4'(TAPS - 1)) begin
                    w_state = S_DRAIN;
                    w_drain = 2'd0;
                end else begin
                    w_tap = r_tap + 4'd1;
                end
            end
            S_DRAIN: begin
                if (r_drain == 2'(DRAIN_CYC - 1)) begin
                    w_state = S_STORE;
                end else begin
                    w_drain = r_drain + 2'd1;
                end
            end
            S_STORE: begin
                if (r_window == 2'd3) begin
                    w_state = S_DONE;
                end else begin
                    w_state  = S_CLR;
                    w_window = r_window + 2'd1;
                end
            end
            S_DONE: begin
                w_state  = S_IDLE;
                w_window = 2'd0;
            end
            default: w_state = S_IDLE;
        endcase
        // Abort wins over every normal transition outside IDLE.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state   = S_IDLE;
            w_window  = 2'd0;
            w_tap     = 4'd0;
            w_drain   = 2'd0;
            w_aborted = 1'b1;
        end
    end

    // Output values for the state being entered; registered below so every
    // output is a flop and lines up with the state register.
    always_comb begin
        w_pe_rst = 1'b0;
        w_pe_on  = 1'b0;
        w_pe_a   = '0;
        w_pe_w   = '0;
        w_c_we   = '0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (w_state)
            S_IDLE: begin
                // One-cycle accumulator clear after an abort.
                w_pe_rst = w_aborted;
            end
            S_CLR: begin
                w_pe_rst = 1'b1;
                w_pe_on  = 1'b1;
                w_busy   = 1'b1;
            end
            S_FEED: begin
                w_pe_on = 1'b1;
                w_busy  = 1'b1;
                // Snapshot is already loaded: FEED is only entered from CLR.
                w_pe_a  = r_img[{w_img_idx, 3'b000} +: DATA_W];
                w_pe_w  = r_ker[{w_ker_idx, 3'b000} +: DATA_W];
            end
            S_DRAIN: begin
                w_pe_on = 1'b1;
                w_busy  = 1'b1;
            end
            S_STORE: begin
                // PE held (pe_on low) while its result is captured.
                w_c_we = 4'b0001 << w_window;
                w_busy = 1'b1;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_window <= '0;
            r_tap    <= '0;
            r_drain  <= '0;
            r_img    <= '0;
            r_ker    <= '0;
            o_pe_rst <= 1'b0;
            o_pe_on  <= 1'b0;
            o_pe_a   <= '0;
            o_pe_w   <= '0;
            o_c_we   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_window <= w_window;
            r_tap    <= w_tap;
            r_drain  <= w_drain;
            if (w_load) begin
                r_img <= i_img;
                r_ker <= i_ker;
            end
            o_pe_rst <= w_pe_rst;
            o_pe_on  <= w_pe_on;
            o_pe_a   <= w_pe_a;
            o_pe_w   <= w_pe_w;
            o_c_we   <= w_c_we;
            o_busy   <= w_busy;
            o_done   <= w_done;
        end
    end

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Bench for pe_conv_sequencer: two instances (DRAIN_CYC=1 and 3) each drive a
// behavioural MAC PE; expected strobes/done are queued by the stimulus and
// popped by per-instance monitors that check cycle, strobe bit and captured value.
module tb_pe_conv_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start1, abort1, start3, abort3;
    logic [127:0] img;
    logic [71:0]  ker;

    logic         pe_rst1, pe_on1, busy1, done1;
    logic [7:0]   pe_a1, pe_w1;
    logic [3:0]   c_we1;
    logic         pe_rst3, pe_on3, busy3, done3;
    logic [7:0]   pe_a3, pe_w3;
    logic [3:0]   c_we3;

    pe_conv_sequencer #(.DRAIN_CYC(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(abort1),
        .i_img(img), .i_ker(ker),
        .o_pe_rst(pe_rst1), .o_pe_on(pe_on1), .o_pe_a(pe_a1), .o_pe_w(pe_w1),
        .o_c_we(c_we1), .o_busy(busy1), .o_done(done1)
    );

    pe_conv_sequencer #(.DRAIN_CYC(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .i_abort(abort3),
        .i_img(img), .i_ker(ker),
        .o_pe_rst(pe_rst3), .o_pe_on(pe_on3), .o_pe_a(pe_a3), .o_pe_w(pe_w3),
        .o_c_we(c_we3), .o_busy(busy3), .o_done(done3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC processing elements.
    int acc1 = 0;
    int acc3 = 0;
    always @(posedge clk) begin
        if (pe_rst1)     acc1 <= 0;
        else if (pe_on1) acc1 <= acc1 + int'(pe_a1) * int'(pe_w1);
        if (pe_rst3)     acc3 <= 0;
        else if (pe_on3) acc3 <= acc3 + int'(pe_a3) * int'(pe_w3);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // we == 0 marks an expected done pulse; otherwise a result strobe.
    typedef struct {
        int         cyc;
        logic [3:0] we;
        int         val;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    task automatic expect_job(input bit third, input int s, input int dc, input int v[4],
                              input int nwin, input bit with_done);
        int   len;
        exp_t e;
        len = 11 + dc;
        for (int k = 0; k < nwin; k++) begin
            e = '{s + (k + 1) * len, 4'(1 << k), v[k]};
            if (third) q3.push_back(e); else q1.push_back(e);
        end
        if (with_done) begin
            e = '{s + 4 * len + 1, 4'd0, 0};
            if (third) q3.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic score(input string tag, input bit have, input exp_t e,
                         input logic [3:0] we, input logic dn, input int acc);
        if (!have) begin
            chk({tag, "_extra_event"}, 32'({dn, we}), 32'd0);
        end else begin
            chk({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
            chk({tag, "_we"}, 32'(we), 32'(e.we));
            chk({tag, "_done"}, 32'(dn), 32'(e.we == 4'd0));
            if (e.we != 4'd0) chk({tag, "_value"}, 32'(acc), 32'(e.val));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   h;
        if (c_we1 != 4'd0 || done1) begin
            h = (q1.size() > 0);
            if (h) e = q1.pop_front(); else e = '{0, 4'd0, 0};
            score("d1", h, e, c_we1, done1, acc1);
        end
        if (c_we3 != 4'd0 || done3) begin
            h = (q3.size() > 0);
            if (h) e = q3.pop_front(); else e = '{0, 4'd0, 0};
            score("d3", h, e, c_we3, done3, acc3);
        end
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) img[8*i +: 8] = 8'(i + 1);
        for (int i = 0; i < 9; i++)  ker[8*i +: 8] = 8'(i + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int exp_a[9];
        exp_a = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        img = '0; ker = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_pe_rst", 32'(pe_rst1), 0);
        chk("rst_pe_on",  32'(pe_on1), 0);
        chk("rst_pe_a",   32'(pe_a1), 0);
        chk("rst_pe_w",   32'(pe_w1), 0);
        chk("rst_c_we",   32'(c_we1), 0);
        chk("rst_busy",   32'(busy1), 0);
        chk("rst_done",   32'(done1), 0);
        chk("rst_busy3",  32'(busy3), 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp job: tap order, snapshot, ignored restarts, results.
        load_ramp();
        s = cyc;
        expect_job(1'b0, s, 1, '{192, 237, 372, 417}, 4, 1'b1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("clr_pe_rst", 32'(pe_rst1), 1);
        chk("clr_pe_on",  32'(pe_on1), 1);
        chk("clr_busy",   32'(busy1), 1);
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            chk("c11_tap_a", 32'(pe_a1), 32'(exp_a[t]));
            chk("c11_tap_w", 32'(pe_w1), 32'(9 - t));
            chk("c11_tap_rst", 32'(pe_rst1), 0);
            if (t == 1) begin
                img = '1;
                ker = '1;
            end
            if (t == 3) begin
                start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
                t++;
                chk("c11_tap_a", 32'(pe_a1), 32'(exp_a[t]));
                chk("c11_tap_w", 32'(pe_w1), 32'(9 - t));
            end
        end
        wait_until(s + 11);
        chk("drain_pe_a", 32'(pe_a1), 0);
        chk("drain_pe_on", 32'(pe_on1), 1);
        wait_until(s + 38);
        chk("c22_first_a", 32'(pe_a1), 6);
        chk("c22_first_w", 32'(pe_w1), 9);
        wait_until(s + 49);
        chk("done_busy", 32'(busy1), 0);
        chk("done_pe_on", 32'(pe_on1), 0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("idle50_busy", 32'(busy1), 0);
        chk("idle50_done", 32'(done1), 0);
        wait_until(s + 70);

        // All-ones job on both instances (drain 1 and drain 3).
        img = {16{8'd1}};
        ker = {9{8'd1}};
        s = cyc;
        expect_job(1'b0, s, 1, '{9, 9, 9, 9}, 4, 1'b1);
        expect_job(1'b1, s, 3, '{9, 9, 9, 9}, 4, 1'b1);
        start1 = 1'b1; start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        wait_until(s + 75);

        // Abort during window C12.
        load_ramp();
        s = cyc;
        expect_job(1'b0, s, 1, '{192, 0, 0, 0}, 1, 1'b0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_until(s + 20);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_busy",   32'(busy1), 0);
        chk("abort_pe_rst", 32'(pe_rst1), 1);
        chk("abort_pe_on",  32'(pe_on1), 0);
        @(negedge clk);
        chk("abort_pe_rst_end", 32'(pe_rst1), 0);
        wait_until(s + 60);

        // Start and abort together in IDLE.
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0;
        chk("sa_busy",   32'(busy1), 0);
        chk("sa_pe_rst", 32'(pe_rst1), 0);
        @(negedge clk);
        chk("sa_busy_later", 32'(busy1), 0);

        // Reset mid-job, then a fresh complete job.
        s = cyc;
        expect_job(1'b0, s, 1, '{192, 237, 0, 0}, 2, 1'b0);
        start1 = 1'b1; abort1 = 1'b1;
        start1 = 1'b1; abort1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        wait_until(s + 30);
        rst = 1'b1; start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        chk("mrst_pe_rst", 32'(pe_rst1), 0);
        chk("mrst_pe_on",  32'(pe_on1), 0);
        chk("mrst_pe_a",   32'(pe_a1), 0);
        chk("mrst_pe_w",   32'(pe_w1), 0);
        chk("mrst_c_we",   32'(c_we1), 0);
        chk("mrst_busy",   32'(busy1), 0);
        chk("mrst_done",   32'(done1), 0);
        @(negedge clk);
        chk("mrst_still_idle", 32'(busy1), 0);
        s = cyc;
        expect_job(1'b0, s, 1, '{192, 237, 372, 417}, 4, 1'b1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_until(s + 70);

        chk("d1_pending", 32'(q1.size()), 0);
        chk("d3_pending", 32'(q3.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
